// File: rtl/bpsk_pkg.sv
// Shared types and constants for the BPSK modulator: FSM states, sample type
// and the quarter-wave sine table used by the NCO.
package bpsk_pkg;

    typedef enum logic {IDLE, SEND} state_t;

    localparam int LUT_AW    = 6;
    localparam int LUT_DEPTH = 1 << LUT_AW;

    typedef logic signed [15:0]      sample_t;
    typedef sample_t [LUT_DEPTH-1:0] sine_table_t;

    localparam real HALF_PI = 1.5707963267948966;

    // Entry k = round(32767*sin(pi/2*(k+0.5)/64)), evaluated at elaboration
    // with a Taylor series that is exact to double precision on [0, pi/2].
    function automatic sine_table_t build_sine_table();
        sine_table_t tbl;
        real         x;
        real         term;
        real         acc;
        tbl = '0;
        for (int k = 0; k < LUT_DEPTH; k++) begin
            x    = HALF_PI * (real'(k) + 0.5) / real'(LUT_DEPTH);
            term = x;
            acc  = x;
            for (int n = 1; n < 12; n++) begin
                term = -term * x * x / real'((2 * n) * (2 * n + 1));
                acc  = acc + term;
            end
            tbl[k] = sample_t'($rtoi(32767.0 * acc + 0.5));
        end
        return tbl;
    endfunction

    localparam sine_table_t SINE_TABLE = build_sine_table();

endpackage

// File: rtl/bpsk_sine_lut.sv
// Registered phase-index to signed sine lookup: folds the 8-bit index onto
// the quarter-wave table and restores the sign, one cycle of latency.
module bpsk_sine_lut
    import bpsk_pkg::*;
(
    input  logic       clk,
    input  logic       rst_n,
    input  logic [7:0] i_idx,
    output sample_t    o_sine
);

    logic [LUT_AW-1:0] w_addr;
    sample_t           w_mag;

    // Quadrants 1 and 3 run the quarter wave backwards; 2 and 3 are negative.
    assign w_addr = i_idx[6] ? ~i_idx[LUT_AW-1:0] : i_idx[LUT_AW-1:0];
    assign w_mag  = SINE_TABLE[w_addr];

    // NOTE: registers take non-blocking assignments so every flop samples
    // the pre-edge values, independent of process evaluation order.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            o_sine <= '0;
        end else begin
            o_sine <= i_idx[7] ? -w_mag : w_mag;
        end
    end

endmodule

// File: rtl/bpsk_modulator.sv
// BPSK transmitter: byte stream in, MSB-first symbols of SPS samples each on
// a free-running NCO carrier. Define BPSK_DIFF_EN for differential encoding.
module bpsk_modulator
    import bpsk_pkg::*;
#(
    parameter int PHASE_W = 32,
    parameter int DATA_W  = 8,
    parameter int SPS     = 64
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic [PHASE_W-1:0] freq_word,
    input  logic [DATA_W-1:0]  s_data,
    input  logic               s_valid,
    output logic               s_ready,
    output sample_t            mod_out,
    output logic               mod_valid,
    output logic               sym_strobe,
    output logic               busy
);

    localparam int CNT_W = $clog2(SPS);
    localparam int BIT_W = (DATA_W > 1) ? $clog2(DATA_W) : 1;
    localparam logic [CNT_W-1:0] LAST_SAMPLE = CNT_W'(SPS - 1);
    localparam logic [BIT_W-1:0] LAST_BIT    = BIT_W'(DATA_W - 1);

    state_t             r_state;
    state_t             w_state_next;
    logic [PHASE_W-1:0] r_phase;
    logic [CNT_W-1:0]   r_sample_cnt;
    logic [BIT_W-1:0]   r_bit_cnt;
    logic [DATA_W-1:0]  r_shift;
    logic               w_load;
    logic               w_last;
    logic               w_first;
    logic               w_tx_bit;
    logic               r_s1_active;
    logic               r_s1_bit;
    logic               r_s1_first;
    sample_t            w_sine;

    assign w_first = (r_state == SEND) && (r_sample_cnt == '0);
    assign w_last  = (r_state == SEND) && (r_sample_cnt == LAST_SAMPLE)
                     && (r_bit_cnt == LAST_BIT);

    // NOTE: every output of this block gets a default first, so no path
    // through the case statement can leave a value held in a latch.
    always_comb begin
        w_state_next = r_state;
        s_ready      = 1'b0;
        w_load       = 1'b0;
        case (r_state)
            IDLE: begin
                s_ready = 1'b1;
                if (s_valid) begin
                    w_load       = 1'b1;
                    w_state_next = SEND;
                end
            end
            SEND: begin
                if (w_last) begin
                    s_ready = 1'b1;
                    if (s_valid) begin
                        w_load = 1'b1;
                    end else begin
                        w_state_next = IDLE;
                    end
                end
            end
            default: w_state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_phase      <= '0;
            r_sample_cnt <= '0;
            r_bit_cnt    <= '0;
            r_shift      <= '0;
        end else begin
            r_phase <= r_phase + freq_word;
            if (w_load) begin
                r_shift      <= s_data;
                r_sample_cnt <= '0;
                r_bit_cnt    <= '0;
            end else if (r_state == SEND) begin
                if (r_sample_cnt == LAST_SAMPLE) begin
                    r_sample_cnt <= '0;
                    if (r_bit_cnt < LAST_BIT) begin
                        r_shift   <= r_shift << 1;
                        r_bit_cnt <= r_bit_cnt + 1'b1;
                    end
                end else begin
                    r_sample_cnt <= r_sample_cnt + 1'b1;
                end
            end
        end
    end

`ifdef BPSK_DIFF_EN
    // r_prev_tx holds the polarity of the symbol in flight once its first
    // sample has gone out, and survives idle gaps between bytes.
    logic r_prev_tx;

    assign w_tx_bit = w_first ? (r_shift[DATA_W-1] ^ r_prev_tx) : r_prev_tx;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_prev_tx <= 1'b0;
        end else if (w_first) begin
            r_prev_tx <= w_tx_bit;
        end
    end
`else
    assign w_tx_bit = r_shift[DATA_W-1];
`endif

    bpsk_sine_lut u_sine_lut (
        .clk    (clk),
        .rst_n  (rst_n),
        .i_idx  (r_phase[PHASE_W-1 -: 8]),
        .o_sine (w_sine)
    );

    // Stage 1 flags travel alongside the LUT register; stage 2 applies the sign.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_s1_active <= 1'b0;
            r_s1_bit    <= 1'b0;
            r_s1_first  <= 1'b0;
            mod_out     <= '0;
            mod_valid   <= 1'b0;
            sym_strobe  <= 1'b0;
        end else begin
            r_s1_active <= (r_state == SEND);
            r_s1_bit    <= w_tx_bit;
            r_s1_first  <= w_first;
            mod_valid   <= r_s1_active;
            sym_strobe  <= r_s1_first;
            if (!r_s1_active) begin
                mod_out <= '0;
            end else begin
                mod_out <= r_s1_bit ? w_sine : -w_sine;
            end
        end
    end

    assign busy = (r_state == SEND) || r_s1_active || mod_valid;

endmodule

// File: tb/tb_bpsk_modulator.sv
// Self-checking bench for bpsk_modulator: a queue-based sample-schedule model
// checked every cycle, plus directed vectors with hand-computed values.
module tb_bpsk_modulator;
    import bpsk_pkg::*;

    localparam int  PHASE_W      = 32;
    localparam int  DATA_W       = 8;
    localparam int  SPS          = 64;
    localparam int  BYTE_SAMPLES = SPS * DATA_W;
    localparam real PI           = 3.141592653589793;
`ifdef BPSK_DIFF_EN
    localparam bit  DIFF = 1'b1;
`else
    localparam bit  DIFF = 1'b0;
`endif

    logic               clk       = 1'b0;
    logic               rst_n     = 1'b0;
    logic [PHASE_W-1:0] freq_word = '0;
    logic [DATA_W-1:0]  s_data    = '0;
    logic               s_valid   = 1'b0;
    logic               s_ready;
    sample_t            mod_out;
    logic               mod_valid;
    logic               sym_strobe;
    logic               busy;

    bpsk_modulator #(.PHASE_W(PHASE_W), .DATA_W(DATA_W), .SPS(SPS)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .freq_word  (freq_word),
        .s_data     (s_data),
        .s_valid    (s_valid),
        .s_ready    (s_ready),
        .mod_out    (mod_out),
        .mod_valid  (mod_valid),
        .sym_strobe (sym_strobe),
        .busy       (busy)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;

    task automatic check(input string name, input int act, input int exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Ideal carrier: sine sampled at the centre of each of 256 phase bins.
    function automatic int sin_ref(input int idx);
        real mag;
        mag = 32767.0 * $sin(2.0 * PI * (real'(idx) + 0.5) / 256.0);
        if (mag >= 0.0) return $rtoi(mag + 0.5);
        return -$rtoi(-mag + 0.5);
    endfunction

    // ---------------- model: one queue entry per future output sample
    typedef struct packed { logic b; logic first; } ent_t;
    typedef struct { bit act; bit first; int val; } exp_t;

    ent_t         q[$];
    exp_t         m_mid = '{act: 1'b0, first: 1'b0, val: 0};
    exp_t         m_out = '{act: 1'b0, first: 1'b0, val: 0};
    logic [31:0]  m_phase = '0;
    bit           m_prev = 1'b0;

    function automatic void model_push(input logic [7:0] d);
        bit b;
        for (int i = DATA_W - 1; i >= 0; i--) begin
            b = d[i];
            if (DIFF) begin
                b      = b ^ m_prev;
                m_prev = b;
            end
            for (int j = 0; j < SPS; j++) q.push_back('{b: b, first: (j == 0)});
        end
    endfunction

    initial begin : model
        bit   accept;
        bit   act;
        ent_t cur;
        forever begin
            @(posedge clk or negedge rst_n);
            if (!rst_n) begin
                q.delete();
                m_phase = '0;
                m_prev  = 1'b0;
                m_mid   = '{act: 1'b0, first: 1'b0, val: 0};
                m_out   = '{act: 1'b0, first: 1'b0, val: 0};
            end else begin
                accept = s_valid && (q.size() <= 1);
                act    = (q.size() > 0);
                cur    = act ? q[0] : '0;
                m_out  = m_mid;
                m_mid.act   = act;
                m_mid.first = act && cur.first;
                m_mid.val   = !act ? 0 : (cur.b ? sin_ref(int'(m_phase[31:24]))
                                                : -sin_ref(int'(m_phase[31:24])));
                if (act) void'(q.pop_front());
                if (accept) model_push(s_data);
                m_phase = m_phase + freq_word;
            end
        end
    end

    initial begin : compare
        forever begin
            @(negedge clk);
            check("mod_out", int'(mod_out), m_out.val);
            check("mod_valid", int'(mod_valid), int'(m_out.act));
            check("sym_strobe", int'(sym_strobe), int'(m_out.first));
            check("s_ready", int'(s_ready), int'(q.size() <= 1));
            check("busy", int'(busy), int'(q.size() > 0 || m_mid.act || m_out.act));
        end
    end

    // ---------------- output log for directed checks
    int log_q[$];
    int strobe_cnt = 0;
    int run_len    = 0;
    int last_run   = 0;

    initial begin : monitor
        forever begin
            @(negedge clk);
            if (mod_valid) begin
                log_q.push_back(int'(mod_out));
                if (sym_strobe) strobe_cnt++;
                run_len++;
            end else begin
                if (run_len > 0) last_run = run_len;
                run_len = 0;
            end
        end
    end

    // Called at a negedge; returns at the negedge after the accepting edge.
    task automatic send(input logic [7:0] d, output int waited);
        bit ok;
        ok     = 1'b0;
        waited = 0;
        s_data  = d;
        s_valid = 1'b1;
        for (int i = 0; i < 4 * BYTE_SAMPLES && !ok; i++) begin
            ok = s_ready;
            if (!ok) waited++;
            @(posedge clk);
            @(negedge clk);
        end
        check("handshake_done", int'(ok), 1);
    endtask

    task automatic wait_idle();
        bit idle;
        idle = 1'b0;
        for (int i = 0; i < 4 * BYTE_SAMPLES && !idle; i++) begin
            @(negedge clk);
            idle = !busy;
        end
        check("went_idle", int'(idle), 1);
        @(negedge clk);
    endtask

    task automatic clear_log();
        log_q.delete();
        strobe_cnt = 0;
    endtask

    initial begin : watchdog
        #1_000_000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "watchdog");
    end

    int a5_exp[8] = '{402, -402, 402, -402, -402, 402, -402, 402};

    initial begin : main
        int waited;
        int vmax;
        int vmin;
        int bad;

        check("ref_idx0", sin_ref(0), 402);
        check("ref_idx63", sin_ref(63), 32765);
        check("ref_idx64", sin_ref(64), 32765);
        check("ref_idx128", sin_ref(128), -402);
        check("ref_idx192", sin_ref(192), -32765);

        // Reset state
        repeat (3) @(negedge clk);
        check("rst_mod_out", int'(mod_out), 0);
        check("rst_mod_valid", int'(mod_valid), 0);
        check("rst_busy", int'(busy), 0);
        check("rst_sym_strobe", int'(sym_strobe), 0);
        rst_n = 1'b1;
        @(negedge clk);
        check("ready_after_rst", int'(s_ready), 1);

        // 0xA5 on an unmodulated (freq 0) carrier
        clear_log();
        send(8'hA5, waited);
        s_valid = 1'b0;
        check("a5_ready_drop", int'(s_ready), 0);
        wait_idle();
        check("a5_len", log_q.size(), BYTE_SAMPLES);
        check("a5_strobes", strobe_cnt, DATA_W);
`ifndef BPSK_DIFF_EN
        if (log_q.size() == BYTE_SAMPLES) begin
            for (int s = 0; s < DATA_W; s++) begin
                check($sformatf("a5_sym%0d_head", s), log_q[s * SPS], a5_exp[s]);
                check($sformatf("a5_sym%0d_tail", s), log_q[s * SPS + SPS - 1], a5_exp[s]);
            end
        end
`endif

        // Back-to-back 0xFF then 0x00
        clear_log();
        send(8'hFF, waited);
        check("b2b_first_wait", waited, 0);
        send(8'h00, waited);
        s_valid = 1'b0;
        check("b2b_ready_low_cycles", waited, BYTE_SAMPLES - 1);
        wait_idle();
        check("b2b_run", last_run, 2 * BYTE_SAMPLES);
        check("b2b_len", log_q.size(), 2 * BYTE_SAMPLES);

        // Fast carrier, 64-sample period, two bytes of 0xFF
        freq_word = 32'h0400_0000;
        clear_log();
        send(8'hFF, waited);
        send(8'hFF, waited);
        s_valid = 1'b0;
        wait_idle();
        check("fast_len", log_q.size(), 2 * BYTE_SAMPLES);
        vmax = -100000;
        vmin = 100000;
        foreach (log_q[i]) begin
            if (log_q[i] > vmax) vmax = log_q[i];
            if (log_q[i] < vmin) vmin = log_q[i];
        end
        check("fast_peak", vmax, 32765);
        check("fast_trough", vmin, -32765);
`ifndef BPSK_DIFF_EN
        bad = 0;
        for (int i = 0; i + 64 < log_q.size(); i++) if (log_q[i] != log_q[i + 64]) bad++;
        check("fast_period_breaks", bad, 0);
`endif

        // Reset in the middle of a byte
        freq_word = '0;
        clear_log();
        send(8'h3C, waited);
        s_valid = 1'b0;
        for (int i = 0; i < 2 * BYTE_SAMPLES && log_q.size() < 100; i++) @(negedge clk);
        check("mid_reached_100", int'(log_q.size() >= 100), 1);
        #2 rst_n = 1'b0;
        #1;
        check("mid_rst_mod_out", int'(mod_out), 0);
        check("mid_rst_mod_valid", int'(mod_valid), 0);
        check("mid_rst_busy", int'(busy), 0);
        check("mid_rst_sym_strobe", int'(sym_strobe), 0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);

        // Clean restart with 0x80: first sample lands at T+3
        clear_log();
        send(8'h80, waited);
        s_valid = 1'b0;
        check("lat_t1_valid", int'(mod_valid), 0);
        @(negedge clk);
        check("lat_t2_valid", int'(mod_valid), 0);
        @(negedge clk);
        check("lat_t3_valid", int'(mod_valid), 1);
        check("lat_t3_value", int'(mod_out), 402);
        check("lat_t3_strobe", int'(sym_strobe), 1);
        wait_idle();
        check("x80_len", log_q.size(), BYTE_SAMPLES);
        bad = 0;
        foreach (log_q[i]) begin
            if (i < SPS && log_q[i] != 402) bad++;
            if (i >= SPS && log_q[i] != (DIFF ? 402 : -402)) bad++;
        end
        check("x80_sample_errors", bad, 0);

`ifdef BPSK_DIFF_EN
        // Differential: 0xFF alternates from +402, then 0x00 holds -402
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        clear_log();
        send(8'hFF, waited);
        send(8'h00, waited);
        s_valid = 1'b0;
        wait_idle();
        check("diff_len", log_q.size(), 2 * BYTE_SAMPLES);
        if (log_q.size() == 2 * BYTE_SAMPLES) begin
            for (int s = 0; s < 2 * DATA_W; s++) begin
                check($sformatf("diff_sym%0d", s), log_q[s * SPS + SPS / 2],
                      (s < DATA_W && s % 2 == 0) ? 402 : -402);
            end
        end
`endif

        repeat (3) @(negedge clk);
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
